// File: rtl/z80_bus_if.sv
// z80_bus_if: Z80 pin-level bus between CPU (master) and bus responder (slave)
//    addr, cpu_data, cpu_data_oe       CPU address / data out / data enables
//    mreq_n, iorq_n, rd_n, wr_n, m1_n  CPU strobes, active low
//    resp_data, resp_drive             responder data and its bus-drive qualifier
//    wait_n, int_n                     responder WAIT and INT, active low
interface z80_bus_if;
   logic [15:0] addr;
   logic [7:0]  cpu_data;
   logic [7:0]  cpu_data_oe;
   logic        mreq_n;
   logic        iorq_n;
   logic        rd_n;
   logic        wr_n;
   logic        m1_n;
   logic [7:0]  resp_data;
   logic        resp_drive;
   logic        wait_n;
   logic        int_n;
   modport master (
      output addr, cpu_data, cpu_data_oe, mreq_n, iorq_n, rd_n, wr_n, m1_n,
      input  resp_data, resp_drive, wait_n, int_n
   );
   modport slave (
      input  addr, cpu_data, cpu_data_oe, mreq_n, iorq_n, rd_n, wr_n, m1_n,
      output resp_data, resp_drive, wait_n, int_n
   );
endinterface

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: cycle-accurate Z80 memory / I/O / interrupt responder with host preload
//    wb_clk_i, rst_n       clock and synchronous active-low reset
//    bus                   Z80 bus (slave side): strobes in, resp_data/resp_drive/wait_n/int_n out
//    irq_set               one-cycle interrupt request pulse
//    load_valid/addr/data  host memory preload, accepted while load_ready is high
//    io_last_port          low address byte of the latest I/O write
//    rd_count              completed read cycles, wrapping
module z80_bus_responder #(
   parameter int         MEM_AW        = 10,
   parameter int         IO_PORTS_LOG2 = 3,
   parameter int         WAIT_STATES   = 1,
   parameter logic [7:0] IRQ_VECTOR    = 8'hFF
) (
   input  logic              wb_clk_i,
   input  logic              rst_n,
   z80_bus_if.slave          bus,
   input  logic              irq_set,
   input  logic              load_valid,
   input  logic [MEM_AW-1:0] load_addr,
   input  logic [7:0]        load_data,
   output logic              load_ready,
   output logic [7:0]        io_last_port,
   output logic [15:0]       rd_count
);
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD, ACK_DRIVE} state_t;
   state_t state;
   logic [7:0] mem [2**MEM_AW];
   logic [7:0] io_reg [2**IO_PORTS_LOG2];
   logic [3:0] cnt;
   logic       is_io;
   logic       idle, one_space, start_ack, start_rd, start_wr, do_load, mem_we, unused_ok;
   logic [MEM_AW-1:0]        ma, mem_wa;
   logic [IO_PORTS_LOG2-1:0] sel;
   logic [7:0]               mem_wd;
   assign idle      = state == IDLE;
   assign ma        = bus.addr[MEM_AW-1:0];
   assign sel       = bus.addr[IO_PORTS_LOG2-1:0];
   // exactly one of mreq_n/iorq_n low; both low without m1_n is ignored
   assign one_space = bus.mreq_n ^ bus.iorq_n;
   assign start_ack = idle & ~bus.m1_n & ~bus.iorq_n;
   assign start_rd  = idle & ~start_ack & ~bus.rd_n & one_space;
   assign start_wr  = idle & ~start_ack & ~start_rd & ~bus.wr_n & one_space;
   // preload is also accepted while held in reset so the host can fill memory before release
   assign do_load   = load_valid & (~rst_n | (idle & ~start_ack & ~start_rd & ~start_wr));
   assign mem_we    = do_load | (rst_n & start_wr & ~bus.mreq_n);
   assign mem_wa    = do_load ? load_addr : ma;
   assign mem_wd    = do_load ? load_data : bus.cpu_data;
   assign unused_ok = ^{bus.cpu_data_oe, bus.addr};
   always_ff @(posedge wb_clk_i)
      if (mem_we) mem[mem_wa] <= mem_wd;
   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         is_io          <= 1'b0;
         bus.resp_data  <= '0;
         bus.resp_drive <= 1'b0;
         bus.wait_n     <= 1'b1;
         bus.int_n      <= 1'b1;
         load_ready     <= 1'b1;
         io_last_port   <= '0;
         rd_count       <= '0;
         io_reg         <= '{default: '0};
      end else begin
         // int_n doubles as the pending flag; a new request beats the acknowledge clear
         bus.int_n <= ~(irq_set | (~bus.int_n & ~start_ack));
         case (state)
            IDLE: begin
               if (start_ack) begin
                  state          <= ACK_DRIVE;
                  bus.resp_drive <= 1'b1;
                  bus.resp_data  <= IRQ_VECTOR;
                  load_ready     <= 1'b0;
               end else if (start_rd) begin
                  is_io      <= ~bus.iorq_n;
                  cnt        <= '0;
                  load_ready <= 1'b0;
                  if (WAIT_STATES == 0) state <= RD_DRIVE;
                  else begin
                     state      <= RD_WAIT;
                     bus.wait_n <= 1'b0;
                  end
               end else if (start_wr) begin
                  state      <= WR_HOLD;
                  load_ready <= 1'b0;
                  if (!bus.iorq_n) begin
                     io_reg[sel]  <= bus.cpu_data;
                     io_last_port <= bus.addr[7:0];
                  end
               end
            end
            RD_WAIT: begin
               if (bus.rd_n) begin
                  state      <= IDLE;
                  bus.wait_n <= 1'b1;
                  load_ready <= 1'b1;
               end else if (cnt + 4'd1 == 4'(WAIT_STATES)) begin
                  state      <= RD_DRIVE;
                  bus.wait_n <= 1'b1;
               end else cnt <= cnt + 4'd1;
            end
            RD_DRIVE: begin
               if (bus.rd_n) begin
                  state          <= IDLE;
                  bus.resp_drive <= 1'b0;
                  rd_count       <= rd_count + 16'd1;
                  load_ready     <= 1'b1;
               end else begin
                  bus.resp_drive <= 1'b1;
                  bus.resp_data  <= is_io ? io_reg[sel] : mem[ma];
               end
            end
            WR_HOLD: begin
               if (bus.wr_n) begin
                  state      <= IDLE;
                  load_ready <= 1'b1;
               end
            end
            ACK_DRIVE: begin
               if (bus.iorq_n) begin
                  state          <= IDLE;
                  bus.resp_drive <= 1'b0;
                  load_ready     <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder: directed plus randomized bus cycles checked against an array-based model
module tb_z80_bus_responder;
   localparam int AW = 10;
   localparam int W  = 1;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   z80_bus_if bus ();
   z80_bus_if bus4 ();
   logic          irq_set = 1'b0;
   logic          load_valid = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [7:0]    load_data = '0;
   logic          load_ready, load_ready4;
   logic [7:0]    io_last_port, io_last_port4;
   logic [15:0]   rd_count, rd_count4;
   z80_bus_responder #(.MEM_AW(AW), .IO_PORTS_LOG2(3), .WAIT_STATES(W), .IRQ_VECTOR(8'hFF)) dut (
      .wb_clk_i(clk), .rst_n(rst_n), .bus(bus), .irq_set(irq_set), .load_valid(load_valid),
      .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready),
      .io_last_port(io_last_port), .rd_count(rd_count)
   );
   z80_bus_responder #(.MEM_AW(AW), .IO_PORTS_LOG2(3), .WAIT_STATES(4), .IRQ_VECTOR(8'hFF)) dut4 (
      .wb_clk_i(clk), .rst_n(rst_n), .bus(bus4), .irq_set(1'b0), .load_valid(1'b0),
      .load_addr('0), .load_data(8'h00), .load_ready(load_ready4),
      .io_last_port(io_last_port4), .rd_count(rd_count4)
   );
   logic [7:0] mem_m [2**AW];
   logic [7:0] io_m [8];
   int         known[$];
   int         rdc = 0;
   logic [7:0] lastp = 8'h00;
   int         checks = 0;
   int         errors = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic idle_bus();
      bus.mreq_n = 1; bus.iorq_n = 1; bus.rd_n = 1; bus.wr_n = 1; bus.m1_n = 1; bus.cpu_data_oe = 8'h00;
   endtask
   task automatic do_read(input logic [15:0] a, input logic io);
      int lat = 0;
      int wl = 0;
      logic [7:0] e;
      @(negedge clk);
      bus.addr = a; bus.mreq_n = io; bus.iorq_n = ~io; bus.rd_n = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (!bus.wait_n) wl++;
         if (bus.resp_drive) break;
      end
      e = io ? io_m[a[2:0]] : mem_m[a[AW-1:0]];
      chk("rd_latency", lat - 1, W + 1);
      chk("rd_wait_cycles", wl, W);
      chk("rd_data", bus.resp_data, e);
      @(negedge clk);
      chk("rd_hold", bus.resp_drive, 1);
      idle_bus();
      rdc++;
      @(negedge clk);
      chk("rd_release", bus.resp_drive, 0);
      chk("rd_count", rd_count, 16'(rdc));
   endtask
   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic io);
      @(negedge clk);
      bus.addr = a; bus.cpu_data = d; bus.cpu_data_oe = 8'hFF; bus.mreq_n = io; bus.iorq_n = ~io; bus.wr_n = 0;
      @(negedge clk);
      chk("wr_busy", load_ready, 0);
      idle_bus();
      @(negedge clk);
      chk("wr_done", load_ready, 1);
      if (io) begin
         io_m[a[2:0]] = d;
         lastp = a[7:0];
         chk("io_last_port", io_last_port, lastp);
      end else begin
         mem_m[a[AW-1:0]] = d;
         known.push_back(int'(a[AW-1:0]));
      end
   endtask
   task automatic do_load(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      load_valid = 1; load_addr = a; load_data = d;
      @(negedge clk);
      load_valid = 0;
      mem_m[a] = d;
      known.push_back(int'(a));
   endtask
   initial begin
      logic [15:0] ra;
      logic [7:0]  rd;
      logic        drove;
      idle_bus();
      bus.addr = '0; bus.cpu_data = '0;
      bus4.addr = '0; bus4.cpu_data = '0; bus4.cpu_data_oe = '0;
      bus4.mreq_n = 1; bus4.iorq_n = 1; bus4.rd_n = 1; bus4.wr_n = 1; bus4.m1_n = 1;
      for (int i = 0; i < 8; i++) io_m[i] = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_resp_drive", bus.resp_drive, 0);
      chk("rst_resp_data", bus.resp_data, 0);
      chk("rst_wait_n", bus.wait_n, 1);
      chk("rst_int_n", bus.int_n, 1);
      chk("rst_load_ready", load_ready, 1);
      chk("rst_io_last_port", io_last_port, 0);
      chk("rst_rd_count", rd_count, 0);
      do_load(10'd0, 8'h31);
      do_load(10'd1, 8'h00);
      do_load(10'd2, 8'h10);
      @(negedge clk);
      rst_n = 1;
      do_read(16'h0001, 0);
      do_read(16'h0000, 0);
      do_read(16'h0002, 0);
      do_write(16'h0405, 8'hA5, 0);
      do_read(16'h0005, 0);
      do_write(16'h0013, 8'h5C, 1);
      do_read(16'h000B, 1);
      // interrupt request and acknowledge
      @(negedge clk); irq_set = 1;
      @(negedge clk); irq_set = 0;
      chk("irq_int_low", bus.int_n, 0);
      @(negedge clk);
      chk("irq_pending", bus.int_n, 0);
      bus.m1_n = 0; bus.iorq_n = 0;
      @(negedge clk);
      chk("ack_drive", bus.resp_drive, 1);
      chk("ack_vector", bus.resp_data, 8'hFF);
      chk("ack_int_clear", bus.int_n, 1);
      idle_bus();
      @(negedge clk);
      chk("ack_release", bus.resp_drive, 0);
      // request coinciding with acknowledge entry stays pending
      irq_set = 1;
      @(negedge clk); irq_set = 0;
      bus.m1_n = 0; bus.iorq_n = 0; irq_set = 1;
      @(negedge clk); irq_set = 0;
      chk("ack_set_wins", bus.int_n, 0);
      idle_bus();
      @(negedge clk);
      bus.m1_n = 0; bus.iorq_n = 0;
      @(negedge clk);
      chk("ack2_int_clear", bus.int_n, 1);
      idle_bus();
      @(negedge clk);
      // mreq_n and iorq_n both low without m1_n is ignored
      bus.addr = 16'h0005; bus.mreq_n = 0; bus.iorq_n = 0; bus.rd_n = 0;
      repeat (3) @(negedge clk);
      chk("illegal_idle", load_ready, 1);
      chk("illegal_wait", bus.wait_n, 1);
      chk("illegal_drive", bus.resp_drive, 0);
      idle_bus();
      // early rd_n release during wait states on the 4-wait-state instance
      @(negedge clk);
      bus4.addr = 16'h0010; bus4.mreq_n = 0; bus4.rd_n = 0;
      @(negedge clk);
      chk("abort_wait1", bus4.wait_n, 0);
      @(negedge clk);
      chk("abort_wait2", bus4.wait_n, 0);
      bus4.mreq_n = 1; bus4.rd_n = 1;
      drove = 0;
      repeat (6) begin
         @(negedge clk);
         drove |= bus4.resp_drive;
      end
      chk("abort_no_drive", drove, 0);
      chk("abort_rd_count", rd_count4, 0);
      chk("abort_idle", load_ready4, 1);
      chk("abort_wait_n", bus4.wait_n, 1);
      // preload attempted during an active read is refused
      do_write(16'h0123, 8'h11, 0);
      @(negedge clk);
      bus.addr = 16'h0005; bus.mreq_n = 0; bus.rd_n = 0;
      @(negedge clk);
      chk("load_busy", load_ready, 0);
      load_valid = 1; load_addr = 10'h123; load_data = 8'hEE;
      @(negedge clk);
      chk("load_busy2", load_ready, 0);
      @(negedge clk);
      load_valid = 0;
      chk("load_rd_drive", bus.resp_drive, 1);
      chk("load_rd_data", bus.resp_data, mem_m[5]);
      idle_bus();
      rdc++;
      @(negedge clk);
      chk("load_ready_back", load_ready, 1);
      do_read(16'h0123, 0);
      do_load(10'h123, 8'hEE);
      do_read(16'h0123, 0);
      // randomized traffic
      for (int n = 0; n < 32; n++) begin
         ra = 16'($urandom);
         rd = 8'($urandom);
         case ($urandom_range(0, 3))
            0: do_write(ra, rd, 0);
            1: do_read({6'($urandom), 10'(known[$urandom_range(0, known.size() - 1)])}, 0);
            2: do_write(ra, rd, 1);
            default: do_read(ra, 1);
         endcase
      end
      // reset in the middle of a read keeps memory but clears everything else
      @(negedge clk);
      bus.addr = 16'h0005; bus.mreq_n = 0; bus.rd_n = 0;
      @(negedge clk);
      rst_n = 0;
      idle_bus();
      @(negedge clk);
      chk("mid_rst_wait_n", bus.wait_n, 1);
      chk("mid_rst_drive", bus.resp_drive, 0);
      chk("mid_rst_rd_count", rd_count, 0);
      chk("mid_rst_io_last", io_last_port, 0);
      rst_n = 1;
      rdc = 0;
      lastp = 8'h00;
      for (int i = 0; i < 8; i++) io_m[i] = 8'h00;
      do_read(16'h0005, 0);
      do_read(16'h0013, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Synthesizable Z80 bus-cycle responder for the chipignite Z80 harness. It sits on the de-swizzled Z80 pins (address, logical-order data bus, control strobes) and provides parametrised-depth memory, an I/O port register file, programmable wait-state insertion and a maskable interrupt source with vector delivery. It replaces passive pin-level stimulus with real cycle-accurate bus behaviour. A host preload port fills memory while the CPU is held in reset.

## Interface

Parameters:
- MEM_AW, 10: memory address bits; depth 2^MEM_AW bytes, mirrored across the 64 KiB space.
- IO_PORTS_LOG2, 3: number of I/O registers is 2^IO_PORTS_LOG2, selected by addr[IO_PORTS_LOG2-1:0].
- WAIT_STATES, 1: wait_n low cycles inserted per memory/IO read (0..15).
- IRQ_VECTOR, 8'hFF: byte driven during interrupt acknowledge.

Ports:
- wb_clk_i  in  1  clock; CPU core shares this clock, all inputs synchronous to it.
- rst_n  in  1  synchronous active-low reset.
- addr  in  16  CPU address bus.
- cpu_data  in  8  CPU data out (logical bit order D7..D0).
- cpu_data_oe  in  8  CPU data output enables (all-ones during writes).
- mreq_n, iorq_n, rd_n, wr_n, m1_n  in  1 each  Z80 strobes, active low.
- resp_data  out  8  data to CPU.
- resp_drive  out  1  high while resp_data is valid on the bus.
- wait_n  out  1  Z80 WAIT, active low.
- int_n  out  1  Z80 INT, active low.
- irq_set  in  1  one-cycle pulse: request interrupt.
- load_valid  in  1  host preload strobe.
- load_addr  in  MEM_AW  preload address.
- load_data  in  8  preload byte.
- load_ready  out  1  high when preload is accepted (only in IDLE).
- io_last_port  out  8  low byte of address of most recent I/O write.
- rd_count  out  16  completed read cycles (memory + I/O), wraps.

## Operation

- FSM states: IDLE, RD_WAIT, RD_DRIVE, WR_HOLD, ACK_DRIVE.
- IDLE: load_ready=1. Priority order, evaluated each cycle:
  1. m1_n=0 & iorq_n=0 -> ACK_DRIVE.
  2. rd_n=0 & (mreq_n=0 xor iorq_n=0) -> RD_WAIT, or RD_DRIVE if WAIT_STATES=0.
  3. wr_n=0 & (mreq_n=0 xor iorq_n=0) -> WR_HOLD, performing the write in the same cycle.
  4. Otherwise, load_valid=1 writes mem[load_addr]=load_data.
- RD_WAIT: wait_n=0. Counter counts WAIT_STATES cycles, then -> RD_DRIVE. If rd_n rises early (CPU reset), abort to IDLE with no count increment.
- RD_DRIVE: resp_drive=1. resp_data = mem[addr[MEM_AW-1:0]] (memory) or io_reg[addr sel] (I/O). Held until rd_n=1, then rd_count+1 and -> IDLE.
- WR_HOLD: memory write stores cpu_data to mem[addr[MEM_AW-1:0]]. I/O write stores to io_reg[sel] and sets io_last_port=addr[7:0]. Only one write per strobe. Stays until wr_n=1 -> IDLE.
- ACK_DRIVE: resp_drive=1, resp_data=IRQ_VECTOR. Clears the int_n pending flag on entry. -> IDLE when iorq_n=1.
- Interrupt: irq_set sets pending (int_n=0). It stays set until acknowledge. irq_set in the same cycle as ACK entry leaves pending set (set wins).
- Both mreq_n and iorq_n low without m1_n is illegal: ignored, FSM stays in IDLE.

## Timing

- Reset values: resp_drive=0, resp_data=0, wait_n=1, int_n=1, load_ready=1, io_last_port=0, rd_count=0, FSM=IDLE, io_reg all 0. Memory contents are not reset.
- All outputs are registered. resp_drive rises the cycle after the transition out of RD_WAIT (or IDLE when WAIT_STATES=0).
- Read latency from the rd_n/strobe sample: WAIT_STATES+1 cycles to resp_drive=1. wait_n is low for exactly WAIT_STATES cycles.
- resp_drive falls the cycle after rd_n/iorq_n is sampled high.
- Write takes effect at the sampling edge. A read of the same address in the next bus cycle returns the new value.
- rd_count wraps 16'hFFFF -> 0.
- Reset mid-cycle: all state returns to reset values on the next edge. Memory contents are kept.

## Test plan

- Preload: mem[0..2]=31 00 10 under rst_n=0. Release reset, then memory read addr=0001 with WAIT_STATES=1. Expect wait_n low 1 cycle, resp_data=00, resp_drive high until rd_n=1, rd_count=1.
- Memory write addr=0x0405 data=0xA5 with MEM_AW=10 (mirrors to 0x005). Then read addr=0x0005: expect 0xA5.
- I/O write port 0x13 data=0x5C (sel=3). Expect io_last_port=0x13. I/O read port 0x0B (sel=3): expect 0x5C.
- irq_set pulse: expect int_n=0 next cycle. Drive m1_n=0 & iorq_n=0: expect resp_data=0xFF, resp_drive=1, and int_n=1 one cycle after ACK entry.
- rd_n released during RD_WAIT (WAIT_STATES=4, release after 2 cycles): expect resp_drive never asserts, rd_count unchanged, FSM back in IDLE.
- load_valid during an active read: expect load_ready=0 and memory unchanged. Retrying the load after the read completes succeeds.
